// File: rtl/data_mem_arbiter_pkg.sv
// Shared constants and types for the data-memory arbiter: memory map base,
// word-index width and the arbiter state encoding.
package data_mem_arbiter_pkg;

  localparam logic [31:0] DATA_MEM_BASE = 32'h1001_0000;
  localparam int          DMEM_ADDR_W   = 10;

  typedef enum logic {
    S_CPU_PRI  = 1'b0,
    S_LD_BURST = 1'b1
  } arb_state_e;

  // Bits needed to hold a counter that saturates at max_val.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/data_mem_arbiter_xlate.sv
// Core byte address to memory word index translation with misalignment and
// range fault detection; purely combinational.
module data_mem_arbiter_xlate
  import data_mem_arbiter_pkg::*;
#(
  parameter int          ADDR_WIDTH = DMEM_ADDR_W,
  parameter logic [31:0] BASE_ADDR  = DATA_MEM_BASE
) (
  input  logic [31:0]           addr_i,
  output logic [ADDR_WIDTH-1:0] idx_o,
  output logic                  fault_o
);

  logic [31:0] off;

  // Below-base addresses wrap to a huge offset and land in the range fault.
  assign off     = addr_i - BASE_ADDR;
  assign idx_o   = off[ADDR_WIDTH+1:2];
  assign fault_o = (off[1:0] != 2'b00) | (off[31:ADDR_WIDTH+2] != '0);

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data memory between the core lw/sw path and a
// word-addressed loader, with a starvation counter and bounded loader bursts.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int          DATA_WIDTH   = 32,
  parameter int          ADDR_WIDTH   = DMEM_ADDR_W,
  parameter logic [31:0] BASE_ADDR    = DATA_MEM_BASE,
  parameter int          STARVE_LIMIT = 4,
  parameter int          MAX_BURST    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [31:0]           cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  output logic                  cpu_stall_o,
  output logic                  cpu_fault_o,
  input  logic                  ld_req_i,
  input  logic                  ld_we_i,
  input  logic [ADDR_WIDTH-1:0] ld_addr_i,
  input  logic [DATA_WIDTH-1:0] ld_wdata_i,
  output logic                  ld_gnt_o,
  output logic [DATA_WIDTH-1:0] ld_rdata_o,
  output logic                  ld_rvalid_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_we_o,
  output logic                  mem_re_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int WAIT_W  = cnt_width(STARVE_LIMIT);
  localparam int BURST_W = cnt_width(MAX_BURST);
  localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(STARVE_LIMIT);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  arb_state_e             state_q, state_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [BURST_W-1:0]     burst_q, burst_d;
  logic                   ld_rvalid_q, ld_rvalid_d;
  logic [DATA_WIDTH-1:0]  ld_rdata_q, ld_rdata_d;

  logic [ADDR_WIDTH-1:0]  cpu_idx;
  logic                   addr_fault;
  logic                   cv;
  logic                   ld_gnt;
  logic                   gnt_cpu;

  data_mem_arbiter_xlate #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR)
  ) u_xlate (
    .addr_i  (cpu_addr_i),
    .idx_o   (cpu_idx),
    .fault_o (addr_fault)
  );

  assign cpu_fault_o = cpu_req_i & addr_fault;
  assign cv          = cpu_req_i & ~addr_fault;

  always_comb begin
    ld_gnt = 1'b0;
    if (ld_req_i) begin
      if (!cv)                      ld_gnt = 1'b1;
      else if (state_q == S_CPU_PRI) ld_gnt = (wait_q == WAIT_MAX);
      else                          ld_gnt = (burst_q < BURST_MAX);
    end
    gnt_cpu = cv & ~ld_gnt;
  end

  assign ld_gnt_o    = ld_gnt;
  assign cpu_stall_o = cv & ~gnt_cpu;
  assign cpu_rdata_o = (gnt_cpu & ~cpu_we_i) ? mem_rdata_i : '0;

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    mem_re_o    = 1'b0;
    if (ld_gnt) begin
      mem_addr_o  = ld_addr_i;
      mem_wdata_o = ld_wdata_i;
      mem_we_o    = ld_we_i;
      mem_re_o    = ~ld_we_i;
    end else if (gnt_cpu) begin
      mem_addr_o  = cpu_idx;
      mem_wdata_o = cpu_wdata_i;
      mem_we_o    = cpu_we_i;
      mem_re_o    = ~cpu_we_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    wait_d      = wait_q;
    ld_rvalid_d = ld_gnt & ~ld_we_i;
    ld_rdata_d  = ld_rdata_q;

    if (!ld_req_i || ld_gnt)   wait_d = '0;
    else if (wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;

    if (ld_gnt && !ld_we_i) ld_rdata_d = mem_rdata_i;

    // Only contended grants move the burst machinery; idle-bus grants are free.
    unique case (state_q)
      S_CPU_PRI: begin
        if (ld_gnt && cv) begin
          state_d = S_LD_BURST;
          burst_d = BURST_W'(1);
        end
      end
      S_LD_BURST: begin
        if (!ld_req_i || (cv && burst_q == BURST_MAX)) begin
          state_d = S_CPU_PRI;
          burst_d = '0;
        end else if (ld_gnt && cv) begin
          burst_d = burst_q + 1'b1;
        end
      end
      default: begin
        state_d = S_CPU_PRI;
        burst_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_CPU_PRI;
      wait_q      <= '0;
      burst_q     <= '0;
      ld_rvalid_q <= 1'b0;
      ld_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      burst_q     <= burst_d;
      ld_rvalid_q <= ld_rvalid_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  assign ld_rvalid_o = ld_rvalid_q;
  assign ld_rdata_o  = ld_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed and randomized bench for data_mem_arbiter with a behavioural
// memory and arbitration reference model.
module tb_data_mem_arbiter;

  localparam int          DW    = 32;
  localparam int          AW    = 10;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          SL    = 4;
  localparam int          MB    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we;
  logic [31:0]   cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall, cpu_fault;
  logic          ld_req, ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata, ld_rdata;
  logic          ld_gnt, ld_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we, mem_re;

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE),
    .STARVE_LIMIT(SL), .MAX_BURST(MB)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata),
    .cpu_stall_o(cpu_stall), .cpu_fault_o(cpu_fault),
    .ld_req_i(ld_req), .ld_we_i(ld_we), .ld_addr_i(ld_addr),
    .ld_wdata_i(ld_wdata), .ld_gnt_o(ld_gnt), .ld_rdata_o(ld_rdata),
    .ld_rvalid_o(ld_rvalid),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we),
    .mem_re_o(mem_re), .mem_rdata_i(mem_rdata)
  );

  // DataMemory stand-in: combinational read, write on the rising edge.
  logic [DW-1:0] dmem [0:DEPTH-1];
  assign mem_rdata = dmem[mem_addr];
  always @(posedge clk) if (mem_we) dmem[mem_addr] <= mem_wdata;

  // Reference model state.
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  int            waits, used;
  bit            bursting;
  logic          e_fault, e_cv, e_gnt, e_cpu, e_rvalid;
  logic [AW-1:0] e_idx;
  logic [DW-1:0] e_ldrdata;
  logic [0:5]    pat;
  int            checks = 0;
  int            fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    waits = 0; used = 0; bursting = 0; e_rvalid = 0; e_ldrdata = '0;
  endtask

  task automatic check_comb();
    logic [31:0] off;
    logic [DW-1:0] e_crd;
    #1;
    off     = cpu_addr - BASE;
    e_fault = cpu_req && ((off % 4) != 0 || off >= 32'(4 * DEPTH));
    e_cv    = cpu_req && !e_fault;
    e_idx   = AW'(off / 4);
    e_gnt   = ld_req && (!e_cv || (bursting ? (used < MB) : (waits >= SL)));
    e_cpu   = e_cv && !e_gnt;
    e_crd   = (e_cpu && !cpu_we) ? ref_mem[e_idx] : '0;
    chk("cpu_fault", cpu_fault, e_fault);
    chk("ld_gnt", ld_gnt, e_gnt);
    chk("cpu_stall", cpu_stall, e_cv && e_gnt);
    chk("cpu_rdata", cpu_rdata, e_crd);
    if (e_gnt) begin
      chk("mem_addr_ld", mem_addr, ld_addr);
      chk("mem_we_ld", mem_we, ld_we);
      chk("mem_re_ld", mem_re, !ld_we);
      chk("mem_wdata_ld", mem_wdata, ld_wdata);
    end else if (e_cpu) begin
      chk("mem_addr_cpu", mem_addr, e_idx);
      chk("mem_we_cpu", mem_we, cpu_we);
      chk("mem_re_cpu", mem_re, !cpu_we);
      chk("mem_wdata_cpu", mem_wdata, cpu_wdata);
    end else begin
      chk("mem_idle", {mem_we, mem_re, 20'(mem_addr)}, 32'd0);
      chk("mem_wdata_idle", mem_wdata, 32'd0);
    end
  endtask

  task automatic commit();
    @(posedge clk);
    if (e_gnt && !ld_we) begin
      e_rvalid  = 1;
      e_ldrdata = ref_mem[ld_addr];
    end else begin
      e_rvalid = 0;
    end
    if (e_gnt && ld_we)       ref_mem[ld_addr] = ld_wdata;
    else if (e_cpu && cpu_we) ref_mem[e_idx]   = cpu_wdata;
    if (!ld_req || e_gnt) waits = 0;
    else if (waits < SL)  waits++;
    if (!bursting) begin
      if (e_gnt && e_cv) begin bursting = 1; used = 1; end
    end else if (!ld_req || (e_cv && used == MB)) begin
      bursting = 0; used = 0;
    end else if (e_gnt && e_cv) begin
      used++;
    end
    #1;
    chk("ld_rvalid", ld_rvalid, e_rvalid);
    chk("ld_rdata", ld_rdata, e_ldrdata);
    @(negedge clk);
  endtask

  task automatic step();
    check_comb();
    commit();
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [31:0] a, input logic [DW-1:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_ld(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_req = req; ld_we = we; ld_addr = a; ld_wdata = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v;
    logic          last_gnt;
    int            r;
    pat = 6'b000011;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      dmem[i] <= v;
      ref_mem[i] = v;
    end
    dmem[5] <= 32'h1234;
    ref_mem[5] = 32'h1234;
    model_reset();
    rst_n = 1'b0;
    set_cpu(0, 0, 32'd0, '0);
    set_ld(0, 0, '0, '0);

    // Reset state and idle combinational outputs.
    #2;
    chk("rst_rvalid", ld_rvalid, 0);
    chk("rst_rdata", ld_rdata, 0);
    chk("rst_idle", {ld_gnt, cpu_stall, cpu_fault, mem_we, mem_re, 10'(mem_addr)}, 0);
    chk("rst_idle_data", mem_wdata | cpu_rdata, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Core store then load.
    set_cpu(1, 1, 32'h1001_0008, 32'hDEAD_BEEF);
    check_comb();
    chk("t1_sw_addr", mem_addr, 2);
    chk("t1_sw_we", mem_we, 1);
    commit();
    set_cpu(1, 0, 32'h1001_0008, '0);
    check_comb();
    chk("t1_lw_addr", mem_addr, 2);
    chk("t1_lw_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("t1_lw_stall", cpu_stall, 0);
    commit();

    // Faulting addresses.
    for (int i = 0; i < 3; i++) begin
      set_cpu(1, 0, (i == 0) ? 32'h1001_0002 : (i == 1) ? 32'h1000_FFFC : 32'h1001_1000, '0);
      check_comb();
      chk("t2_fault", cpu_fault, 1);
      chk("t2_mem_re", mem_re, 0);
      chk("t2_stall", cpu_stall, 0);
      chk("t2_rdata", cpu_rdata, 0);
      commit();
    end

    // Continuous contention.
    for (int i = 0; i < 12; i++) begin
      set_cpu(1, 0, BASE + 32'(4 * (i + 10)), '0);
      set_ld(1, 0, AW'(100 + i), '0);
      check_comb();
      chk("t3_ld_gnt", ld_gnt, pat[i % 6]);
      chk("t3_stall", cpu_stall, pat[i % 6]);
      commit();
    end

    // Fresh start, then an uncontended loader read.
    set_cpu(0, 0, 32'd0, '0);
    set_ld(0, 0, '0, '0);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_ld(1, 0, AW'(5), '0);
    check_comb();
    chk("t4_gnt", ld_gnt, 1);
    commit();
    chk("t4_rvalid", ld_rvalid, 1);
    chk("t4_rdata", ld_rdata, 32'h1234);
    set_ld(0, 0, '0, '0);
    step();
    chk("t4_rvalid_once", ld_rvalid, 0);

    // Reset in the first loader cycle of a burst.
    for (int i = 0; i < 5; i++) begin
      set_cpu(1, 0, BASE + 32'(4 * i), '0);
      set_ld(1, 0, AW'(200 + i), '0);
      if (i < 4) step();
    end
    check_comb();
    chk("t5_first_ld", ld_gnt, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_rdata", ld_rdata, 0);
    @(posedge clk); #1;
    chk("t5_rst_rvalid", ld_rvalid, 0);
    chk("t5_rst_rdata_hold", ld_rdata, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_comb();
      chk("t5_after_gnt", ld_gnt, pat[i]);
      commit();
    end

    // Loader withdraws mid-burst while the core keeps requesting.
    set_ld(0, 0, '0, '0);
    check_comb();
    chk("t6_drop_stall", cpu_stall, 0);
    commit();
    set_ld(1, 0, AW'(7), '0);
    check_comb();
    chk("t6_cpu_pri_gnt", ld_gnt, 0);
    chk("t6_cpu_pri_stall", cpu_stall, 0);
    commit();

    // Randomized traffic with loader requests held until granted.
    last_gnt = 1'b1;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      cpu_addr = BASE + 32'($urandom_range(0, 8191));
      else if (r == 1) cpu_addr = BASE - 32'($urandom_range(1, 64));
      else             cpu_addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      cpu_req   = ($urandom_range(0, 3) != 0);
      cpu_we    = $urandom_range(0, 1) == 1;
      cpu_wdata = $urandom;
      if (last_gnt || !ld_req)
        set_ld($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
               AW'($urandom_range(0, DEPTH - 1)), $urandom);
      check_comb();
      last_gnt = e_gnt;
      commit();
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
